// File: rtl/frame_result_writer.sv
// Write-back stage of the 3x3 neighbourhood pipeline: drops the window fill latency,
// raster-addresses the result frame memory and forces border pixels to a constant.
module frame_result_writer #(
    parameter int unsigned IMG_W      = 512,
    parameter int unsigned IMG_H      = 512,
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned SKIP       = 514,
    parameter logic [7:0]  BORDER_VAL = 8'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        din,
    input  logic              din_valid,
    output logic [ADDR_W-1:0] waddr,
    output logic [7:0]        wdata,
    output logic              we,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned SKIP_W = (SKIP > 1) ? $clog2(SKIP) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(IMG_W * IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [SKIP_W-1:0]   skip_cnt_q, skip_cnt_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [ADDR_W-1:0]   pix_addr_q, pix_addr_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic                is_border;

    assign is_border = (row_q == '0) || (row_q == ROW_LAST) ||
                       (col_q == '0) || (col_q == COL_LAST);

    always_comb begin
        state_d      = state_q;
        skip_cnt_d   = skip_cnt_q;
        col_d        = col_q;
        row_d        = row_q;
        pix_addr_d   = pix_addr_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        we_d         = 1'b0;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    skip_cnt_d = '0;
                    col_d      = '0;
                    row_d      = '0;
                    pix_addr_d = '0;
                    busy_d     = 1'b1;
                    state_d    = (SKIP == 0) ? WRITE : FILL;
                end
            end
            FILL: begin
                // The sample that completes the fill count is the last discarded one.
                if (din_valid) begin
                    if (skip_cnt_q == SKIP_LAST) begin
                        state_d = WRITE;
                    end else begin
                        skip_cnt_d = skip_cnt_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (din_valid) begin
                    we_d    = 1'b1;
                    waddr_d = pix_addr_q;
                    wdata_d = is_border ? BORDER_VAL : din;
                    if (pix_addr_q == PIX_LAST) begin
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        pix_addr_d = pix_addr_q + 1'b1;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                frame_done_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            skip_cnt_q   <= '0;
            col_q        <= '0;
            row_q        <= '0;
            pix_addr_q   <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            skip_cnt_q   <= skip_cnt_d;
            col_q        <= col_d;
            row_q        <= row_d;
            pix_addr_q   <= pix_addr_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign we         = we_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
